// File: rtl/receiver_pkg.sv
// Shared 802.11a framing definitions: field widths, descrambler constants,
// receiver state encoding and the symbol-boundary counter helper.
package receiver_pkg;

    localparam int N_DBPS        = 24;
    localparam int PREAMBLE_BITS = 96;
    localparam int RATE_BITS     = 4;
    localparam int LEN_BITS      = 12;
    localparam int SIG_TAIL_BITS = 6;
    localparam int SERVICE_BITS  = 16;
    localparam int TAIL_BITS     = 6;

    // x^7 + x^4 + 1 : feedback taken from s[6] and s[3]
    localparam logic [6:0] LFSR_TAPS = 7'b100_1000;
    localparam logic [6:0] SEED      = 7'h7F;

    // field/align counter must hold LENGTH*8 (up to 32760)
    localparam int FLD_W = 15;
    localparam int CNT_W = 16;

    typedef enum logic [3:0] {
        ST_HUNT,
        ST_SYNC,
        ST_RATE,
        ST_RESERVED,
        ST_LENGTH,
        ST_PARITY,
        ST_SIG_TAIL,
        ST_SERVICE,
        ST_PSDU,
        ST_DATA_TAIL,
        ST_PAD
    } rx_state_e;

    // frame bit position modulo N_DBPS
    function automatic logic [CNT_W-1:0] sym_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_W'(N_DBPS - 1)) ? '0 : c + CNT_W'(1);
    endfunction

endpackage

// File: rtl/receiver_descrambler.sv
// Additive x^7+x^4+1 descrambler. Load forces the state to SEED for the
// current bit, so the first SERVICE bit is descrambled with the seed itself.
module descrambler
    import receiver_pkg::*;
(
    input  logic Clock,
    input  logic Reset,
    input  logic Load,
    input  logic Enable,
    input  logic Input,
    output logic Output
);

    logic [6:0] s_q, s_d, cur;
    logic       fb;

    // effective state, keystream bit and next state
    always_comb begin
        cur    = Load ? SEED : s_q;
        fb     = ^(cur & LFSR_TAPS);
        Output = Input ^ fb;
        s_d    = (Load || Enable) ? {cur[5:0], fb} : s_q;
    end

    // LFSR state register
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) s_q <= '0;
        else        s_q <= s_d;
    end

endmodule

// File: rtl/receiver.sv
// Serial 802.11a frame receiver: preamble lock, SIGNAL parse/check,
// DATA descrambling and PSDU bit output, padding to N_DBPS boundaries.
module receiver
    import receiver_pkg::*;
(
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Input,
    output logic                Data_out,
    output logic                Data_valid,
    output logic [RATE_BITS-1:0] Rate,
    output logic [LEN_BITS-1:0]  Length,
    output logic                Signal_valid,
    output logic                Signal_error,
    output logic                Frame_done,
    output logic                Busy
);

    rx_state_e              state_q, state_d;
    logic [FLD_W-1:0]       fld_q, fld_d, fld_inc, psdu_bits;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   prev_q, prev_d;
    logic [RATE_BITS-1:0]   rsh_q, rsh_d, rate_q, rate_d;
    logic [LEN_BITS-1:0]    lsh_q, lsh_d, len_q, len_d;
    logic                   res_q, res_d;
    logic                   par_q, par_d;
    logic                   dout_q, dout_d;
    logic                   dval_q, dval_d;
    logic                   sv_q, sv_d;
    logic                   se_q, se_d;
    logic                   fd_q, fd_d;
    logic                   busy_q, busy_d;
    logic                   ds_load, ds_en, ds_out;

    descrambler u_descr (
        .Clock  (Clock),
        .Reset  (Reset),
        .Load   (ds_load),
        .Enable (ds_en),
        .Input  (Input),
        .Output (ds_out)
    );

    assign psdu_bits = {len_q, 3'b000};

    // parser next-state and output decode, one line bit per cycle
    always_comb begin
        state_d = state_q;
        fld_d   = fld_q;
        fld_inc = fld_q + FLD_W'(1);
        cnt_d   = sym_inc(cnt_q);
        prev_d  = Input;
        rsh_d   = rsh_q;
        lsh_d   = lsh_q;
        res_d   = res_q;
        par_d   = par_q;
        rate_d  = rate_q;
        len_d   = len_q;
        dout_d  = 1'b0;
        dval_d  = 1'b0;
        sv_d    = 1'b0;
        se_d    = 1'b0;
        fd_d    = 1'b0;
        busy_d  = busy_q;
        ds_load = 1'b0;
        ds_en   = 1'b0;

        unique case (state_q)
            ST_HUNT: begin
                cnt_d = '0;
                if (Input) begin
                    state_d = ST_SYNC;
                    fld_d   = FLD_W'(1);
                    cnt_d   = CNT_W'(1);
                    busy_d  = 1'b1;
                end
            end
            ST_SYNC: begin
                if (Input == prev_q) begin
                    if (Input) begin
                        // a repeated 1 may itself be the start of a preamble
                        fld_d = FLD_W'(1);
                        cnt_d = CNT_W'(1);
                    end else begin
                        state_d = ST_HUNT;
                        fld_d   = '0;
                        cnt_d   = '0;
                        busy_d  = 1'b0;
                    end
                end else if (fld_inc == FLD_W'(PREAMBLE_BITS)) begin
                    state_d = ST_RATE;
                    fld_d   = '0;
                    par_d   = 1'b0;
                end else begin
                    fld_d = fld_inc;
                end
            end
            ST_RATE: begin
                rsh_d = {rsh_q[RATE_BITS-2:0], Input};
                par_d = par_q ^ Input;
                fld_d = fld_inc;
                if (fld_inc == FLD_W'(RATE_BITS)) begin
                    state_d = ST_RESERVED;
                    fld_d   = '0;
                end
            end
            ST_RESERVED: begin
                res_d   = Input;
                par_d   = par_q ^ Input;
                state_d = ST_LENGTH;
            end
            ST_LENGTH: begin
                lsh_d = {lsh_q[LEN_BITS-2:0], Input};
                par_d = par_q ^ Input;
                fld_d = fld_inc;
                if (fld_inc == FLD_W'(LEN_BITS)) begin
                    state_d = ST_PARITY;
                    fld_d   = '0;
                end
            end
            ST_PARITY: begin
                if (!(par_q ^ Input) && !res_q) begin
                    rate_d  = rsh_q;
                    len_d   = lsh_q;
                    sv_d    = 1'b1;
                    state_d = ST_SIG_TAIL;
                end else begin
                    se_d    = 1'b1;
                    state_d = ST_HUNT;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                end
            end
            ST_SIG_TAIL: begin
                fld_d = fld_inc;
                if (fld_inc == FLD_W'(SIG_TAIL_BITS)) begin
                    state_d = ST_SERVICE;
                    fld_d   = '0;
                end
            end
            ST_SERVICE: begin
                ds_load = (fld_q == '0);
                ds_en   = 1'b1;
                fld_d   = fld_inc;
                if (fld_inc == FLD_W'(SERVICE_BITS)) begin
                    state_d = (len_q == '0) ? ST_DATA_TAIL : ST_PSDU;
                    fld_d   = '0;
                end
            end
            ST_PSDU: begin
                ds_en  = 1'b1;
                dout_d = ds_out;
                dval_d = 1'b1;
                fld_d  = fld_inc;
                if (fld_inc == psdu_bits) begin
                    state_d = ST_DATA_TAIL;
                    fld_d   = '0;
                end
            end
            ST_DATA_TAIL: begin
                ds_en = 1'b1;
                fld_d = fld_inc;
                if (fld_inc == FLD_W'(TAIL_BITS)) begin
                    fld_d = '0;
                    if (cnt_d == '0) begin
                        state_d = ST_HUNT;
                        fd_d    = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = ST_PAD;
                    end
                end
            end
            ST_PAD: begin
                ds_en = 1'b1;
                if (cnt_d == '0) begin
                    state_d = ST_HUNT;
                    fd_d    = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_HUNT;
                fld_d   = '0;
                cnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // state, counters and registered outputs
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_HUNT;
            fld_q   <= '0;
            cnt_q   <= '0;
            prev_q  <= 1'b0;
            rsh_q   <= '0;
            lsh_q   <= '0;
            res_q   <= 1'b0;
            par_q   <= 1'b0;
            rate_q  <= '0;
            len_q   <= '0;
            dout_q  <= 1'b0;
            dval_q  <= 1'b0;
            sv_q    <= 1'b0;
            se_q    <= 1'b0;
            fd_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            fld_q   <= fld_d;
            cnt_q   <= cnt_d;
            prev_q  <= prev_d;
            rsh_q   <= rsh_d;
            lsh_q   <= lsh_d;
            res_q   <= res_d;
            par_q   <= par_d;
            rate_q  <= rate_d;
            len_q   <= len_d;
            dout_q  <= dout_d;
            dval_q  <= dval_d;
            sv_q    <= sv_d;
            se_q    <= se_d;
            fd_q    <= fd_d;
            busy_q  <= busy_d;
        end
    end

    assign Data_out     = dout_q;
    assign Data_valid   = dval_q;
    assign Rate         = rate_q;
    assign Length       = len_q;
    assign Signal_valid = sv_q;
    assign Signal_error = se_q;
    assign Frame_done   = fd_q;
    assign Busy         = busy_q;

endmodule

// File: tb/tb_receiver.sv
// Directed bench for the 802.11a serial receiver.
module tb_receiver;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Input;
    logic        Data_out, Data_valid, Signal_valid, Signal_error, Frame_done, Busy;
    logic [3:0]  Rate;
    logic [11:0] Length;

    int checks = 0;
    int errors = 0;

    logic fq[$];
    logic rxq[$];
    int   fd_idx[$];
    int   idx, dv_cnt, sv_cnt, se_cnt, fd_cnt, sv_idx, se_idx;
    logic busy_seen;

    always #5 Clock = ~Clock;

    receiver dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .Input        (Input),
        .Data_out     (Data_out),
        .Data_valid   (Data_valid),
        .Rate         (Rate),
        .Length       (Length),
        .Signal_valid (Signal_valid),
        .Signal_error (Signal_error),
        .Frame_done   (Frame_done),
        .Busy         (Busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        idx = 0; dv_cnt = 0; sv_cnt = 0; se_cnt = 0; fd_cnt = 0;
        sv_idx = -1; se_idx = -1; busy_seen = 1'b0;
        rxq.delete();
        fd_idx.delete();
    endtask

    // drive one bit, then observe the outputs registered from it
    task automatic send_bit(input logic b);
        Input = b;
        @(posedge Clock);
        #1;
        idx++;
        if (Data_valid)   begin dv_cnt++; rxq.push_back(Data_out); end
        if (Signal_valid) begin sv_cnt++; sv_idx = idx; end
        if (Signal_error) begin se_cnt++; se_idx = idx; end
        if (Frame_done)   begin fd_cnt++; fd_idx.push_back(idx); end
        if (Busy)         busy_seen = 1'b1;
    endtask

    task automatic send_all();
        while (fq.size() > 0) send_bit(fq.pop_front());
    endtask

    // append a complete frame; PSDU byte i = i, scrambled from SEED at SERVICE
    task automatic add_frame(input logic [3:0] r, input logic [11:0] l, input logic badpar);
        logic [6:0] s;
        logic [7:0] bv;
        logic       p, fb, b;
        int         nb, tot;
        for (int i = 0; i < 96; i++) fq.push_back(~i[0]);
        p = (^r) ^ (^l) ^ badpar;
        for (int i = 3; i >= 0; i--) fq.push_back(r[i]);
        fq.push_back(1'b0);
        for (int i = 11; i >= 0; i--) fq.push_back(l[i]);
        fq.push_back(p);
        repeat (6) fq.push_back(1'b0);
        nb  = int'(l) * 8;
        tot = ((22 + nb + 23) / 24) * 24;
        s   = 7'h7F;
        for (int k = 0; k < tot; k++) begin
            b = 1'b0;
            if (k >= 16 && k < 16 + nb) begin
                bv = 8'((k - 16) / 8);
                b  = bv[7 - ((k - 16) % 8)];
            end
            fb = s[6] ^ s[3];
            fq.push_back(b ^ fb);
            s = {s[5:0], fb};
        end
    endtask

    function automatic int byte_errs(input int first, input int nbytes);
        int         e;
        logic [7:0] v;
        e = 0;
        for (int i = 0; i < nbytes; i++) begin
            for (int j = 0; j < 8; j++)
                v[7 - j] = ((first + i) * 8 + j < rxq.size()) ? rxq[(first + i) * 8 + j] : 1'bx;
            if (v !== 8'(i)) e++;
        end
        return e;
    endfunction

    function automatic int fd_at(input int n);
        return (n < fd_idx.size()) ? fd_idx[n] : -1;
    endfunction

    initial begin
        Reset = 1'b0;
        Input = 1'b0;
        repeat (3) @(posedge Clock);
        #1;
        chk("rst_busy",  32'(Busy), 0);
        chk("rst_dval",  32'(Data_valid), 0);
        chk("rst_dout",  32'(Data_out), 0);
        chk("rst_sv",    32'(Signal_valid), 0);
        chk("rst_se",    32'(Signal_error), 0);
        chk("rst_fd",    32'(Frame_done), 0);
        chk("rst_rate",  32'(Rate), 0);
        chk("rst_len",   32'(Length), 0);
        @(negedge Clock);
        Reset = 1'b1;

        // reference frame
        clear_mon();
        add_frame(4'b1101, 12'd16, 1'b0);
        send_all();
        chk("ref_sv_cnt",   sv_cnt, 1);
        chk("ref_sv_idx",   sv_idx, 114);
        chk("ref_se_cnt",   se_cnt, 0);
        chk("ref_dv_cnt",   dv_cnt, 128);
        chk("ref_bytes",    byte_errs(0, 16), 0);
        chk("ref_fd_cnt",   fd_cnt, 1);
        chk("ref_fd_idx",   fd_at(0), 288);
        chk("ref_rate",     32'(Rate), 32'b1101);
        chk("ref_len",      32'(Length), 16);
        chk("ref_busy_end", 32'(Busy), 0);
        chk("ref_busy_mid", 32'(busy_seen), 1);

        // parity flipped
        clear_mon();
        add_frame(4'b1101, 12'd16, 1'b1);
        for (int i = 0; i < 114; i++) send_bit(fq.pop_front());
        fq.delete();
        repeat (10) send_bit(1'b0);
        chk("par_se_cnt", se_cnt, 1);
        chk("par_se_idx", se_idx, 114);
        chk("par_sv_cnt", sv_cnt, 0);
        chk("par_dv_cnt", dv_cnt, 0);
        chk("par_fd_cnt", fd_cnt, 0);
        chk("par_busy",   32'(Busy), 0);
        chk("par_rate",   32'(Rate), 32'b1101);
        chk("par_len",    32'(Length), 16);

        // broken preamble then a full frame
        clear_mon();
        for (int i = 0; i < 40; i++) send_bit(~i[0]);
        send_bit(1'b1);
        send_bit(1'b1);
        chk("brk_pulses", sv_cnt + se_cnt + fd_cnt + dv_cnt, 0);
        clear_mon();
        add_frame(4'b1101, 12'd16, 1'b0);
        send_all();
        chk("brk_sv_idx", sv_idx, 114);
        chk("brk_dv_cnt", dv_cnt, 128);
        chk("brk_bytes",  byte_errs(0, 16), 0);
        chk("brk_fd_idx", fd_at(0), 288);

        // zero-length PSDU
        clear_mon();
        add_frame(4'b0101, 12'd0, 1'b0);
        send_all();
        chk("l0_sv_cnt", sv_cnt, 1);
        chk("l0_dv_cnt", dv_cnt, 0);
        chk("l0_fd_cnt", fd_cnt, 1);
        chk("l0_fd_idx", fd_at(0), 144);
        chk("l0_rate",   32'(Rate), 32'b0101);
        chk("l0_len",    32'(Length), 0);
        chk("l0_busy",   32'(Busy), 0);

        // back-to-back frames
        clear_mon();
        add_frame(4'b1101, 12'd16, 1'b0);
        add_frame(4'b1101, 12'd16, 1'b0);
        send_all();
        chk("b2b_sv_cnt", sv_cnt, 2);
        chk("b2b_dv_cnt", dv_cnt, 256);
        chk("b2b_fd_cnt", fd_cnt, 2);
        chk("b2b_fd0",    fd_at(0), 288);
        chk("b2b_fd1",    fd_at(1), 576);
        chk("b2b_bytes0", byte_errs(0, 16), 0);
        chk("b2b_bytes1", byte_errs(16, 16), 0);
        chk("b2b_len",    32'(Length), 16);

        // reset in the middle of the PSDU (at PSDU bit 50)
        clear_mon();
        add_frame(4'b1101, 12'd16, 1'b0);
        for (int i = 0; i < 185; i++) send_bit(fq.pop_front());
        fq.delete();
        chk("mid_dv_before", dv_cnt, 49);
        Input = 1'b1;
        #2;
        Reset = 1'b0;
        #1;
        chk("mid_busy", 32'(Busy), 0);
        chk("mid_dval", 32'(Data_valid), 0);
        chk("mid_rate", 32'(Rate), 0);
        chk("mid_len",  32'(Length), 0);
        Input = 1'b0;
        repeat (3) @(posedge Clock);
        #1;
        chk("mid_fd", 32'(Frame_done), 0);
        @(negedge Clock);
        Reset = 1'b1;
        clear_mon();
        add_frame(4'b1101, 12'd16, 1'b0);
        send_all();
        chk("post_sv_cnt", sv_cnt, 1);
        chk("post_dv_cnt", dv_cnt, 128);
        chk("post_bytes",  byte_errs(0, 16), 0);
        chk("post_fd_idx", fd_at(0), 288);
        chk("post_rate",   32'(Rate), 32'b1101);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
